// File: rtl/nic_traffic_generator.sv
// nic_traffic_generator
//   Synthesizable packet injector for NIC/router test harnesses. Builds
//   fixed-length packets whose destination comes from a 32-bit Galois LFSR,
//   biased toward the local PE by PE_PERCENT. It drives one network input
//   channel under credit-based flow control.
//
// Ports
//   clk                system clock
//   reset              asynchronous, active-high reset
//   start_din          start request, honoured only in IDLE/DONE
//   packet_total_din   number of packets to send, latched on start
//   credit_in_din      one-cycle pulse = one downstream buffer slot freed
//   flit_dout          flit data (holds its last value while stalled)
//   flit_valid_dout    high for exactly one cycle per issued flit
//   busy_dout          generation in progress
//   done_dout          all requested packets sent, held until next start
//   packets_sent_dout  tail flits issued since start
//   credits_dout       current downstream credit count
//   credit_error_dout  sticky: credit returned while the counter was full
module nic_traffic_generator #(
   parameter int          FLIT_WIDTH   = 32,
   parameter int          PACKET_FLITS = 5,
   parameter int          X_WIDTH      = 4,
   parameter int          Y_WIDTH      = 4,
   parameter int          X_LOCAL      = 2,
   parameter int          Y_LOCAL      = 2,
   parameter int          PE_PERCENT   = 8,
   parameter int          CREDITS      = 4,
   parameter int          COUNT_WIDTH  = 16,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2015,
   localparam int         CRED_W       = $clog2(CREDITS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_din,
   input  logic [COUNT_WIDTH-1:0] packet_total_din,
   input  logic                   credit_in_din,
   output logic [FLIT_WIDTH-1:0]  flit_dout,
   output logic                   flit_valid_dout,
   output logic                   busy_dout,
   output logic                   done_dout,
   output logic [COUNT_WIDTH-1:0] packets_sent_dout,
   output logic [CRED_W-1:0]      credits_dout,
   output logic                   credit_error_dout
);

   localparam int K_W        = $clog2(PACKET_FLITS);
   localparam int THRESH     = (PE_PERCENT * 256) / 100;
   localparam int HDR_ROOM   = FLIT_WIDTH - X_WIDTH - Y_WIDTH;
   localparam int HDR_IDX_W  = (COUNT_WIDTH < HDR_ROOM) ? COUNT_WIDTH : HDR_ROOM;
   localparam int BODY_IDX_W = FLIT_WIDTH - 8;

   localparam logic [31:0]          LFSR_TAPS = 32'h8020_0003;  // x^32+x^22+x^2+x+1
   localparam logic [8:0]           THRESH9   = 9'(THRESH);     // 9 bits so 100% -> 256
   localparam logic [X_WIDTH-1:0]   XL        = X_WIDTH'(X_LOCAL);
   localparam logic [Y_WIDTH-1:0]   YL        = Y_WIDTH'(Y_LOCAL);
   localparam logic [K_W-1:0]       K_TAIL    = K_W'(PACKET_FLITS - 1);
   localparam logic [K_W-1:0]       K_ONE     = K_W'(1);
   localparam logic [CRED_W-1:0]    CRED_MAX  = CRED_W'(CREDITS);
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

   typedef enum logic [2:0] {IDLE, LOAD, HEAD, BODY, DONE} state_t;

   state_t                 state, state_next;
   logic [31:0]            lfsr, lfsr_adv;
   logic [X_WIDTH-1:0]     dest_x, sel_x;
   logic [Y_WIDTH-1:0]     dest_y, sel_y;
   logic [COUNT_WIDTH-1:0] total;
   logic [K_W-1:0]         k;
   logic [FLIT_WIDTH-1:0]  hdr_flit, body_flit;
   logic                   start_ok, send, tail, last_pkt;

   // Send and return in the same cycle cancel; a return into a full counter
   // saturates (the error flag is raised separately).
   function automatic logic [CRED_W-1:0] credit_next(input logic [CRED_W-1:0] cur,
                                                     input logic used,
                                                     input logic returned);
      logic [CRED_W-1:0] r;
      r = cur;
      if (used && !returned)
         r = cur - CRED_W'(1);
      else if (!used && returned && cur != CRED_MAX)
         r = cur + CRED_W'(1);
      return r;
   endfunction

   // Destination select from the freshly advanced LFSR value.
   always_comb begin
      lfsr_adv = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
      sel_x    = XL;
      sel_y    = YL;
      if ({1'b0, lfsr_adv[7:0]} >= THRESH9) begin
         sel_x = lfsr_adv[8 +: X_WIDTH];
         sel_y = lfsr_adv[16 +: Y_WIDTH];
         // A random pick landing on the local node would skew the bias upward.
         if (sel_x == XL && sel_y == YL)
            sel_x[0] = ~sel_x[0];
      end
   end

   // Flit formats: header carries the destination in the top bits and the
   // packet index in the low bits; body flits carry index and flit number.
   always_comb begin
      hdr_flit                                  = '0;
      hdr_flit[FLIT_WIDTH-1 -: X_WIDTH]         = dest_x;
      hdr_flit[FLIT_WIDTH-X_WIDTH-1 -: Y_WIDTH] = dest_y;
      hdr_flit[HDR_IDX_W-1:0]                   = packets_sent_dout[HDR_IDX_W-1:0];
      body_flit = {BODY_IDX_W'(packets_sent_dout), 8'(k)};
   end

   // Credits are taken from the registered count only, so a credit arriving
   // this cycle becomes usable next cycle.
   assign start_ok = (state == IDLE || state == DONE) && start_din;
   assign send     = (state == HEAD || state == BODY) && (credits_dout != '0);
   assign tail     = (state == BODY) && (k == K_TAIL);
   assign last_pkt = (packets_sent_dout + CNT_ONE) == total;

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE: if (start_din) state_next = (packet_total_din == '0) ? DONE : LOAD;
         LOAD:       state_next = HEAD;
         HEAD:       if (send) state_next = BODY;
         BODY:       if (send && tail) state_next = last_pkt ? DONE : LOAD;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr              <= LFSR_SEED;
         dest_x            <= '0;
         dest_y            <= '0;
         total             <= '0;
         k                 <= '0;
         flit_dout         <= '0;
         flit_valid_dout   <= 1'b0;
         busy_dout         <= 1'b0;
         done_dout         <= 1'b0;
         packets_sent_dout <= '0;
         credits_dout      <= CRED_MAX;
         credit_error_dout <= 1'b0;
      end else begin
         busy_dout <= (state_next == LOAD) || (state_next == HEAD) || (state_next == BODY);
         done_dout <= (state_next == DONE);

         if (start_ok) begin
            total             <= packet_total_din;
            packets_sent_dout <= '0;
         end else if (send && tail) begin
            packets_sent_dout <= packets_sent_dout + CNT_ONE;
         end

         if (state == LOAD) begin
            lfsr   <= lfsr_adv;
            dest_x <= sel_x;
            dest_y <= sel_y;
         end

         flit_valid_dout <= send;
         if (send) begin
            flit_dout <= (state == HEAD) ? hdr_flit : body_flit;
            k         <= (state == HEAD) ? K_ONE : k + K_ONE;
         end

         credits_dout <= credit_next(credits_dout, send, credit_in_din);
         if (credit_in_din && !send && credits_dout == CRED_MAX)
            credit_error_dout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nic_traffic_generator.sv
// Testbench for nic_traffic_generator. The main instance (PE_PERCENT=8) is
// checked flit by flit through an expected-flit queue; two side instances
// (PE_PERCENT=100 and 0) share the control inputs and are checked for their
// destination bias during the long run.
module tb_nic_traffic_generator;

   localparam logic [31:0] SEED = 32'hACE1_2015;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, credit_man;
   logic [15:0] total_in;
   int          loop_mode;

   logic [31:0] flit;
   logic        fv, busy, done, cerr, credit_main;
   logic [15:0] psent;
   logic [2:0]  cred;
   logic [2:0]  dly;

   logic [31:0] s_flit [2];
   logic        s_fv [2], s_busy [2], s_done [2], s_cerr [2], s_cin [2];
   logic [15:0] s_ps [2];
   logic [2:0]  s_cr [2];
   logic [2:0]  s_dly [2];

   nic_traffic_generator dut (
      .clk(clk), .reset(reset), .start_din(start), .packet_total_din(total_in),
      .credit_in_din(credit_main), .flit_dout(flit), .flit_valid_dout(fv),
      .busy_dout(busy), .done_dout(done), .packets_sent_dout(psent),
      .credits_dout(cred), .credit_error_dout(cerr));

   nic_traffic_generator #(.PE_PERCENT(100)) u_p100 (
      .clk(clk), .reset(reset), .start_din(start), .packet_total_din(total_in),
      .credit_in_din(s_cin[0]), .flit_dout(s_flit[0]), .flit_valid_dout(s_fv[0]),
      .busy_dout(s_busy[0]), .done_dout(s_done[0]), .packets_sent_dout(s_ps[0]),
      .credits_dout(s_cr[0]), .credit_error_dout(s_cerr[0]));

   nic_traffic_generator #(.PE_PERCENT(0)) u_p0 (
      .clk(clk), .reset(reset), .start_din(start), .packet_total_din(total_in),
      .credit_in_din(s_cin[1]), .flit_dout(s_flit[1]), .flit_valid_dout(s_fv[1]),
      .busy_dout(s_busy[1]), .done_dout(s_done[1]), .packets_sent_dout(s_ps[1]),
      .credits_dout(s_cr[1]), .credit_error_dout(s_cerr[1]));

   // Credit loopback: mode 1 returns a credit in the cycle the flit is valid,
   // mode 3 returns it three cycles later. Side instances always use mode 3.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dly      <= '0;
         s_dly[0] <= '0;
         s_dly[1] <= '0;
      end else begin
         dly      <= {dly[1:0], fv};
         s_dly[0] <= {s_dly[0][1:0], s_fv[0]};
         s_dly[1] <= {s_dly[1][1:0], s_fv[1]};
      end
   end
   assign credit_main = credit_man | ((loop_mode == 1) & fv) | ((loop_mode == 3) & dly[2]);
   assign s_cin[0] = s_dly[0][2];
   assign s_cin[1] = s_dly[1][2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] flit;
      int          tcyc;   // required cycle, or -1 when timing is not checked
      bit          hdr;
   } exp_t;
   exp_t q[$];

   int total_n = 0, bad_n = 0;
   int flits_seen = 0, local_hdrs = 0;
   bit stats_en = 1'b0;
   int s_pos [2] = '{0, 0};
   int s_hdrs [2] = '{0, 0};
   int s_local [2] = '{0, 0};
   logic [31:0] m_lfsr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total_n++;
      if (act !== req) begin
         bad_n++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      total_n++;
      if (act < lo || act > hi) begin
         bad_n++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic [31:0] adv(input logic [31:0] l);
      return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Expected packet from the destination rules: 8% of 256 -> threshold 20.
   task automatic push_model_packet(input int idx);
      logic [3:0]  x, y;
      logic [15:0] ix;
      exp_t        e;
      ix     = 16'(idx);
      m_lfsr = adv(m_lfsr);
      if (m_lfsr[7:0] < 8'd20) begin
         x = 4'd2; y = 4'd2;
      end else begin
         x = m_lfsr[11:8]; y = m_lfsr[19:16];
         if (x == 4'd2 && y == 4'd2) x[0] = ~x[0];
      end
      e.flit = {x, y, 8'h00, ix}; e.tcyc = -1; e.hdr = 1'b1;
      q.push_back(e);
      for (int kk = 1; kk <= 4; kk++) begin
         e.flit = {8'h00, ix, 8'(kk)}; e.tcyc = -1; e.hdr = 1'b0;
         q.push_back(e);
      end
   endtask

   // First packet after reset, hand-computed: seed 0xACE12015 advances to
   // 0xD6509009, low byte 9 < 20 -> local (2,2); header index 0.
   task automatic push_first_packet(input int t0);
      logic [31:0] tbl [5];
      exp_t        e;
      tbl[0] = 32'h2200_0000; tbl[1] = 32'h0000_0001; tbl[2] = 32'h0000_0002;
      tbl[3] = 32'h0000_0003; tbl[4] = 32'h0000_0004;
      for (int i = 0; i < 5; i++) begin
         e.flit = tbl[i]; e.tcyc = t0 + 2 + i; e.hdr = (i == 0);
         q.push_back(e);
      end
   endtask

   // Monitor: pops the expected flit whenever a DUT flit is valid.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && fv) begin
            flits_seen++;
            if (q.size() == 0) begin
               chk("unexpected_flit", {31'h0, fv}, 32'h0);
            end else begin
               e = q.pop_front();
               chk("flit_data", flit, e.flit);
               if (e.tcyc >= 0) chk("flit_cycle", cyc, e.tcyc);
               if (e.hdr && stats_en && flit[31:24] == 8'h22) local_hdrs++;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (reset) begin
               s_pos[i] = 0;
            end else if (s_fv[i]) begin
               if (s_pos[i] == 0 && stats_en) begin
                  s_hdrs[i]++;
                  if (s_flit[i][31:24] == 8'h22) s_local[i]++;
               end
               s_pos[i] = (s_pos[i] == 4) ? 0 : s_pos[i] + 1;
            end
         end
      end
   end

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, {31'h0, done}, 32'h1);
   endtask

   initial begin
      int t0, n0;
      reset = 1'b1; start = 1'b0; credit_man = 1'b0; total_in = '0; loop_mode = 0;
      m_lfsr = SEED;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("idle_valid", {31'h0, fv}, 32'h0);
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_done", {31'h0, done}, 32'h0);
      chk("idle_credits", {29'h0, cred}, 32'd4);
      chk("idle_sent", {16'h0, psent}, 32'h0);
      chk("idle_cerr", {31'h0, cerr}, 32'h0);
      chk("idle_flit", flit, 32'h0);

      // Single local packet with credits returned as flits issue.
      loop_mode = 1;
      m_lfsr = adv(m_lfsr);
      t0 = cyc + 1;
      push_first_packet(t0);
      total_in = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 1) chk("load_busy", {31'h0, busy}, 32'h1);
         if (i >= 3 && i <= 6) chk("credit_send_cancel", {29'h0, cred}, 32'd3);
      end
      chk("a_done", {31'h0, done}, 32'h1);
      chk("a_sent", {16'h0, psent}, 32'd1);
      chk("a_credits", {29'h0, cred}, 32'd4);
      chk("a_busy", {31'h0, busy}, 32'h0);

      // Credit starvation: four flits, stall, one credit frees the tail.
      loop_mode = 0;
      repeat (20) @(negedge clk);
      push_model_packet(0);
      total_in = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (12) @(negedge clk);
      chk("stall_credits", {29'h0, cred}, 32'd0);
      chk("stall_valid", {31'h0, fv}, 32'h0);
      chk("stall_busy", {31'h0, busy}, 32'h1);
      chk("stall_pending", q.size(), 32'd1);
      credit_man = 1'b1;
      @(negedge clk); credit_man = 1'b0;
      chk("credit_not_same_cycle", {31'h0, fv}, 32'h0);
      chk("credit_one", {29'h0, cred}, 32'd1);
      @(negedge clk);
      chk("tail_after_credit", {31'h0, fv}, 32'h1);
      @(negedge clk);
      chk("b_done", {31'h0, done}, 32'h1);
      chk("b_credits", {29'h0, cred}, 32'd0);
      repeat (4) begin
         credit_man = 1'b1; @(negedge clk);
         credit_man = 1'b0; @(negedge clk);
      end
      chk("restored_credits", {29'h0, cred}, 32'd4);
      chk("restored_cerr", {31'h0, cerr}, 32'h0);
      credit_man = 1'b1; @(negedge clk);
      credit_man = 1'b0; @(negedge clk);
      chk("saturate_credits", {29'h0, cred}, 32'd4);
      chk("credit_error", {31'h0, cerr}, 32'h1);

      // Zero-length request.
      n0 = flits_seen;
      total_in = 16'd0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("zero_done", {31'h0, done}, 32'h1);
      chk("zero_busy", {31'h0, busy}, 32'h0);
      repeat (10) @(negedge clk);
      chk("zero_no_flits", flits_seen - n0, 32'd0);

      // Long run with a three-cycle credit loopback.
      loop_mode = 3;
      repeat (5) @(negedge clk);
      stats_en = 1'b1; local_hdrs = 0; n0 = flits_seen;
      for (int i = 0; i < 2000; i++) push_model_packet(i);
      total_in = 16'd2000; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      wait_done(40000, "long_done");
      chk("long_sent", {16'h0, psent}, 32'd2000);
      chk("long_flits", flits_seen - n0, 32'd10000);
      chk("long_pending", q.size(), 32'd0);
      chk_range("local_pct8", local_hdrs, 100, 220);
      for (int n = 0; n < 200 && !(s_done[0] && s_done[1]); n++) @(negedge clk);
      chk("p100_hdrs", s_hdrs[0], 32'd2000);
      chk("p100_local", s_local[0], 32'd2000);
      chk("p0_hdrs", s_hdrs[1], 32'd2000);
      chk("p0_local", s_local[1], 32'd0);
      stats_en = 1'b0;

      // Reset in the middle of a packet, then restart from the seed.
      loop_mode = 1;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 3; i++) push_model_packet(i);
      total_in = 16'd3; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_body_k2", flit, 32'h0000_0002);
      #1 reset = 1'b1;
      #1;
      chk("rst_flit", flit, 32'h0);
      chk("rst_valid", {31'h0, fv}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_credits", {29'h0, cred}, 32'd4);
      chk("rst_sent", {16'h0, psent}, 32'h0);
      chk("rst_cerr", {31'h0, cerr}, 32'h0);
      q.delete();
      m_lfsr = adv(SEED);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      t0 = cyc + 1;
      push_first_packet(t0);
      total_in = 16'd1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      chk("restart_sent", {16'h0, psent}, 32'd1);
      chk("restart_done", {31'h0, done}, 32'h1);
      chk("restart_pending", q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
